stall_flush_controller: RTL and testbench



---
 rtl/stall_flush_controller.sv | 140 ++++++++++++++
 tb/tb_stall_flush_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_flush_controller.sv
// Pipeline hazard controller: load-use, jump, mispredict and mul/div stalls/flushes.
// Optional perf counters (stall_cycles, flush_events) exist only when HAZARD_PERF_CNT_EN is defined.
module stall_flush_controller #(
  parameter int MULDIV_MAX_WAIT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hzd_exe_to_id_A,
  input  logic        hzd_mem_to_exe_A,
  input  logic        hzd_mem_to_exe_B,
  input  logic        id_jump_taken,
  input  logic        exe_branch_mispredict,
  input  logic        exe_muldiv_start,
  input  logic        exe_muldiv_done,
  output logic        if_stall,
  output logic        id_stall,
  output logic        exe_stall,
  output logic        id_flush,
  output logic        exe_flush,
  output logic        mem_flush,
  output logic        replay_A,
  output logic        replay_B,
  output logic        muldiv_timeout,
  output logic [1:0]  fsm_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam int WD_W = $clog2(MULDIV_MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_STALL  = 2'd1,
    MULDIV_WAIT = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WD_W-1:0]   wd_cnt, wd_n;
  logic              replay_a_n, replay_b_n, timeout_set;

  assign fsm_state = state;

  // Mul/div handshake: exe_muldiv_start marks the op's first EXE cycle; exe_muldiv_done
  // marks the cycle its result is valid. Done in the start cycle means no wait at all.
  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    exe_stall   = 1'b0;
    id_flush    = 1'b0;
    exe_flush   = 1'b0;
    mem_flush   = 1'b0;
    state_n     = state;
    wd_n        = wd_cnt;
    replay_a_n  = 1'b0;
    replay_b_n  = 1'b0;
    timeout_set = 1'b0;
    if (!rst) begin
      case (state)
        MULDIV_WAIT: begin
          state_n = IDLE;
          if (exe_muldiv_done) begin
            state_n = IDLE;
          end else if (wd_cnt == WD_W'(MULDIV_MAX_WAIT)) begin
            timeout_set = 1'b1;
          end else begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            exe_stall = 1'b1;
            mem_flush = 1'b1;
            wd_n      = wd_cnt + WD_W'(1);
            state_n   = MULDIV_WAIT;
          end
        end
        default: begin
          state_n = IDLE;
          if (exe_branch_mispredict) begin
            id_flush  = 1'b1;
            exe_flush = 1'b1;
          end else if (state == IDLE) begin
            if (hzd_mem_to_exe_A || hzd_mem_to_exe_B) begin
              if_stall   = 1'b1;
              id_stall   = 1'b1;
              exe_stall  = 1'b1;
              mem_flush  = 1'b1;
              replay_a_n = hzd_mem_to_exe_A;
              replay_b_n = hzd_mem_to_exe_B;
              state_n    = LOAD_STALL;
            end else if (hzd_exe_to_id_A) begin
              if_stall  = 1'b1;
              id_stall  = 1'b1;
              exe_flush = 1'b1;
              state_n   = LOAD_STALL;
            end else if (exe_muldiv_start && !exe_muldiv_done) begin
              if_stall  = 1'b1;
              id_stall  = 1'b1;
              exe_stall = 1'b1;
              mem_flush = 1'b1;
              wd_n      = WD_W'(1);
              state_n   = MULDIV_WAIT;
            end
          end
          // A jump held in ID by a stall is flushed once the stall drops.
          if (id_jump_taken && !id_stall) id_flush = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wd_cnt         <= '0;
      replay_A       <= 1'b0;
      replay_B       <= 1'b0;
      muldiv_timeout <= 1'b0;
    end else begin
      state    <= state_n;
      wd_cnt   <= wd_n;
      replay_A <= replay_a_n;
      replay_B <= replay_b_n;
      if (timeout_set) muldiv_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (if_stall && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if ((id_flush || exe_flush) && flush_events != 32'hFFFF_FFFF) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_flush_controller.sv
// Bench for stall_flush_controller: directed scenarios plus random traffic vs a cycle model.
module tb_stall_flush_controller;
  localparam int MAX_WAIT = 40;
  localparam logic [6:0] I_NONE  = 7'b0000000;
  localparam logic [6:0] I_EA    = 7'b1000000;
  localparam logic [6:0] I_MA    = 7'b0100000;
  localparam logic [6:0] I_MB    = 7'b0010000;
  localparam logic [6:0] I_JMP   = 7'b0001000;
  localparam logic [6:0] I_MIS   = 7'b0000100;
  localparam logic [6:0] I_START = 7'b0000010;
  localparam logic [6:0] I_DONE  = 7'b0000001;
  localparam int M_RUN = 0, M_AFTER_LOAD = 1, M_WAIT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic hzd_exe_to_id_A = 0, hzd_mem_to_exe_A = 0, hzd_mem_to_exe_B = 0;
  logic id_jump_taken = 0, exe_branch_mispredict = 0, exe_muldiv_start = 0, exe_muldiv_done = 0;
  logic if_stall, id_stall, exe_stall, id_flush, exe_flush, mem_flush;
  logic replay_A, replay_B, muldiv_timeout;
  logic [1:0] fsm_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  stall_flush_controller #(.MULDIV_MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .hzd_exe_to_id_A(hzd_exe_to_id_A), .hzd_mem_to_exe_A(hzd_mem_to_exe_A),
    .hzd_mem_to_exe_B(hzd_mem_to_exe_B), .id_jump_taken(id_jump_taken),
    .exe_branch_mispredict(exe_branch_mispredict), .exe_muldiv_start(exe_muldiv_start),
    .exe_muldiv_done(exe_muldiv_done),
    .if_stall(if_stall), .id_stall(id_stall), .exe_stall(exe_stall),
    .id_flush(id_flush), .exe_flush(exe_flush), .mem_flush(mem_flush),
    .replay_A(replay_A), .replay_B(replay_B), .muldiv_timeout(muldiv_timeout),
    .fsm_state(fsm_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  // {if_stall,id_stall,exe_stall,id_flush,exe_flush,mem_flush,replay_A,replay_B,muldiv_timeout}
  logic [8:0] obs;
  assign obs = {if_stall, id_stall, exe_stall, id_flush, exe_flush, mem_flush,
                replay_A, replay_B, muldiv_timeout};

  int checks = 0;
  int errors = 0;

  // reference model: pipeline mode, pending replay, wait count, sticky error, counters
  int m_mode = M_RUN, n_mode;
  bit m_ra = 0, m_rb = 0, m_to = 0, n_ra, n_rb, n_to;
  int m_wait = 0, n_wait;
  longint m_sc = 0, m_fe = 0, n_sc, n_fe;
  logic [8:0] exp_o;

  task automatic model_eval();
    bit s_if, s_id, s_exe, f_id, f_exe, f_mem;
    {s_if, s_id, s_exe, f_id, f_exe, f_mem} = '0;
    n_ra = 0; n_rb = 0; n_mode = M_RUN; n_wait = m_wait; n_to = m_to; n_sc = m_sc; n_fe = m_fe;
    if (rst) begin
      n_wait = 0; n_to = 0; n_sc = 0; n_fe = 0;
    end else begin
      if (m_mode == M_WAIT) begin
        if (!exe_muldiv_done) begin
          if (m_wait >= MAX_WAIT) n_to = 1;
          else begin
            {s_if, s_id, s_exe, f_mem} = 4'b1111;
            n_wait = m_wait + 1; n_mode = M_WAIT;
          end
        end
      end else begin
        if (exe_branch_mispredict) begin
          f_id = 1; f_exe = 1;
        end else if (m_mode == M_RUN) begin
          if (hzd_mem_to_exe_A || hzd_mem_to_exe_B) begin
            {s_if, s_id, s_exe, f_mem} = 4'b1111;
            n_ra = hzd_mem_to_exe_A; n_rb = hzd_mem_to_exe_B; n_mode = M_AFTER_LOAD;
          end else if (hzd_exe_to_id_A) begin
            s_if = 1; s_id = 1; f_exe = 1; n_mode = M_AFTER_LOAD;
          end else if (exe_muldiv_start && !exe_muldiv_done) begin
            {s_if, s_id, s_exe, f_mem} = 4'b1111;
            n_wait = 1; n_mode = M_WAIT;
          end
        end
        if (id_jump_taken && !s_id) f_id = 1;
      end
      if (s_if && n_sc < 64'hFFFF_FFFF) n_sc = n_sc + 1;
      if ((f_id || f_exe) && n_fe < 64'hFFFF_FFFF) n_fe = n_fe + 1;
    end
    exp_o = {s_if, s_id, s_exe, f_id, f_exe, f_mem, m_ra, m_rb, m_to};
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1ns later
  task automatic drive(input logic r, input logic [6:0] v);
    @(negedge clk);
    rst = r;
    {hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B, id_jump_taken,
     exe_branch_mispredict, exe_muldiv_start, exe_muldiv_done} = v;
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    m_mode = n_mode; m_ra = n_ra; m_rb = n_rb; m_wait = n_wait; m_to = n_to;
    m_sc = n_sc; m_fe = n_fe;
  endtask

  task automatic test_reset();
    drive(1, 7'($urandom_range(0, 127))); advance();
    drive(1, 7'($urandom_range(0, 127)));
    checks++; if (obs !== 9'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, 9'b0); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    advance();
    drive(0, I_NONE); advance();
  endtask

  task automatic test_load_b();
    drive(0, I_MB);
    checks++; if (obs !== 9'b111001000) begin errors++; $display("FAIL load_b_stall got=%b exp=111001000", obs); end
    advance();
    drive(0, I_NONE);
    checks++; if (obs !== 9'b000000010) begin errors++; $display("FAIL load_b_replay got=%b exp=000000010", obs); end
    advance();
    drive(0, I_NONE);
    checks++; if (obs !== 9'b000000000) begin errors++; $display("FAIL load_b_clear got=%b exp=000000000", obs); end
    advance();
  endtask

  task automatic test_jump_behind_stall();
    drive(0, I_EA | I_JMP);
    checks++; if (obs !== 9'b110010000) begin errors++; $display("FAIL jump_held got=%b exp=110010000", obs); end
    advance();
    drive(0, I_JMP);
    checks++; if (obs !== 9'b000100000) begin errors++; $display("FAIL jump_release got=%b exp=000100000", obs); end
    advance();
    drive(0, I_NONE); advance();
  endtask

  task automatic test_muldiv_done();
    for (int i = 0; i < 6; i++) begin
      drive(0, i == 0 ? I_START : (i == 4 ? I_DONE : I_NONE));
      if (i < 4) begin
        checks++; if (obs !== 9'b111001000) begin errors++; $display("FAIL muldiv_stall c%0d got=%b exp=111001000", i, obs); end
      end else begin
        checks++; if (obs !== 9'b0) begin errors++; $display("FAIL muldiv_release c%0d got=%b exp=000000000", i, obs); end
      end
      if (i == 2) begin
        checks++; if (fsm_state !== 2'd2) begin errors++; $display("FAIL muldiv_wait_state got=%0d exp=2", fsm_state); end
      end
      if (i == 5) begin
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL muldiv_idle_state got=%0d exp=0", fsm_state); end
      end
      advance();
    end
  endtask

  task automatic test_muldiv_timeout();
    int stalled = 0;
    for (int i = 0; i < 45; i++) begin
      drive(0, i == 0 ? I_START : I_NONE);
      if (obs[8]) stalled++;
      if (i == 40) begin
        checks++; if (obs !== 9'b0) begin errors++; $display("FAIL timeout_release got=%b exp=000000000", obs); end
      end
      if (i == 44) begin
        checks++; if (obs !== 9'b000000001) begin errors++; $display("FAIL timeout_sticky got=%b exp=000000001", obs); end
      end
      advance();
    end
    checks++; if (stalled != MAX_WAIT) begin errors++; $display("FAIL timeout_stall_len got=%0d exp=%0d", stalled, MAX_WAIT); end
    drive(1, I_NONE);
    checks++; if (obs !== 9'b000000001) begin errors++; $display("FAIL timeout_in_rst got=%b exp=000000001", obs); end
    advance();
    drive(0, I_NONE);
    checks++; if (obs !== 9'b0) begin errors++; $display("FAIL timeout_cleared got=%b exp=000000000", obs); end
    advance();
  endtask

  task automatic test_mispredict_hazard();
    drive(0, I_MIS | I_MA);
    checks++; if (obs !== 9'b000110000) begin errors++; $display("FAIL mispredict_flush got=%b exp=000110000", obs); end
    advance();
    drive(0, I_NONE);
    checks++; if (obs !== 9'b0) begin errors++; $display("FAIL mispredict_no_replay got=%b exp=000000000", obs); end
    advance();
  endtask

  task automatic test_back_to_back();
    drive(0, I_MA); advance();
    drive(0, I_MA);
    checks++; if (obs !== 9'b000000100) begin errors++; $display("FAIL b2b_masked got=%b exp=000000100", obs); end
    advance();
    drive(0, I_MB);
    checks++; if (obs !== 9'b111001000) begin errors++; $display("FAIL b2b_second got=%b exp=111001000", obs); end
    advance();
    drive(0, I_NONE);
    checks++; if (obs !== 9'b000000010) begin errors++; $display("FAIL b2b_replay got=%b exp=000000010", obs); end
    advance();
  endtask

  task automatic test_reset_mid_stall();
    drive(0, I_START); advance();
    drive(0, I_NONE); advance();
    drive(1, I_START);
    checks++; if (obs !== 9'b0) begin errors++; $display("FAIL rst_mid_muldiv got=%b exp=000000000", obs); end
    advance();
    drive(0, I_NONE);
    checks++; if (obs !== 9'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL rst_after_muldiv got=%b/%0d exp=000000000/0", obs, fsm_state); end
    advance();
    drive(1, I_MA); advance();
    drive(0, I_NONE);
    checks++; if (obs !== 9'b0) begin errors++; $display("FAIL rst_no_replay got=%b exp=000000000", obs); end
    advance();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    drive(1, I_NONE); advance();
    drive(0, I_MB); advance();
    drive(0, I_NONE); advance();
    drive(0, I_MIS); advance();
    drive(0, I_NONE);
    checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL perf_stall got=%0d exp=1", stall_cycles); end
    checks++; if (flush_events !== 32'd1) begin errors++; $display("FAIL perf_flush got=%0d exp=1", flush_events); end
    advance();
  endtask
`endif

  task automatic test_random();
    logic [6:0] v;
    for (int n = 0; n < 400; n++) begin
      v = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0};
      drive($urandom_range(0, 79) == 0, v);
      checks++; if (obs !== exp_o) begin errors++; $display("FAIL random_c%0d in=%b got=%b exp=%b", n, v, obs, exp_o); end
`ifdef HAZARD_PERF_CNT_EN
      checks++; if (stall_cycles !== 32'(m_sc) || flush_events !== 32'(m_fe)) begin
        errors++; $display("FAIL random_perf_c%0d got=%0d/%0d exp=%0d/%0d", n, stall_cycles, flush_events, m_sc, m_fe);
      end
`endif
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_load_b();
    test_jump_behind_stall();
    test_muldiv_done();
    test_muldiv_timeout();
    test_mispredict_hazard();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
